// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the DIV/DIVU sequencer: FSM encoding, widths,
// result slicing and per-IP one-hot routing.
package div_ctrl_pkg;

  localparam int DIV_OP_WD  = 32;
  localparam int DIV_RES_WD = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  // IP result layout is {quotient, remainder}
  function automatic logic [DIV_OP_WD-1:0] quot_of(input logic [DIV_RES_WD-1:0] res);
    return res[63:32];
  endfunction

  function automatic logic [DIV_OP_WD-1:0] rem_of(input logic [DIV_RES_WD-1:0] res);
    return res[31:0];
  endfunction

  // Bit 1 addresses the signed IP, bit 0 the unsigned IP
  function automatic logic [1:0] sel_onehot(input logic sel, input logic val);
    return sel ? {val, 1'b0} : {1'b0, val};
  endfunction

endpackage

// File: rtl/div_chan_tracker.sv
// One AXI-Stream operand channel: raises tvalid while sending until its
// handshake, then remembers that the beat has been delivered.
module div_chan_tracker (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic tready,
  output logic tvalid,
  output logic done
);

  logic sent_reg;

  assign tvalid = active & ~sent_reg;
  // done includes a handshake happening in the current cycle
  assign done   = sent_reg | (tvalid & tready);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      sent_reg <= 1'b0;
    end else if (tvalid && tready) begin
      sent_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the signed/unsigned divider IP pair: sends latched operands,
// captures and holds the result, and drains results of cancelled requests.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_signed,
  input  logic [DIV_OP_WD-1:0]  req_dividend,
  input  logic [DIV_OP_WD-1:0]  req_divisor,
  input  logic                  cancel,
  input  logic                  res_accept,
  output logic                  res_valid,
  output logic [DIV_OP_WD-1:0]  res_quot,
  output logic [DIV_OP_WD-1:0]  res_rem,
  output logic                  busy,
  output logic [1:0]            s_dvd_tvalid,
  output logic [1:0]            s_dvs_tvalid,
  input  logic [1:0]            s_dvd_tready,
  input  logic [1:0]            s_dvs_tready,
  output logic [DIV_OP_WD-1:0]  s_dvd_tdata,
  output logic [DIV_OP_WD-1:0]  s_dvs_tdata,
  input  logic [1:0]            m_dout_tvalid,
  input  logic [DIV_RES_WD-1:0] m_dout_tdata_s,
  input  logic [DIV_RES_WD-1:0] m_dout_tdata_u
);

  div_state_e            state_reg;
  logic                  sel_reg;
  logic                  cancel_pend_reg;
  logic [DIV_OP_WD-1:0]  dvd_reg;
  logic [DIV_OP_WD-1:0]  dvs_reg;
  logic [DIV_RES_WD-1:0] res_reg;

  logic                  start_req;
  logic                  in_send;
  logic                  dout_sel;
  logic [DIV_RES_WD-1:0] dout_data;
  logic [DIV_RES_WD-1:0] res_data;
  logic [1:0]            chan_tready;
  logic [1:0]            chan_tvalid;
  logic [1:0]            chan_done;

  assign start_req = (state_reg == ST_IDLE) & req_valid & ~cancel;
  assign in_send   = (state_reg == ST_SEND);

  // Only the selected IP's channels and result are ever looked at
  assign chan_tready[0] = sel_reg ? s_dvd_tready[1] : s_dvd_tready[0];
  assign chan_tready[1] = sel_reg ? s_dvs_tready[1] : s_dvs_tready[0];
  assign dout_sel       = sel_reg ? m_dout_tvalid[1] : m_dout_tvalid[0];
  assign dout_data      = sel_reg ? m_dout_tdata_s : m_dout_tdata_u;

  // Channel 0 carries the dividend, channel 1 the divisor
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      div_chan_tracker u_trk (
        .clk    (clk),
        .reset  (reset),
        .start  (start_req),
        .active (in_send),
        .tready (chan_tready[gi]),
        .tvalid (chan_tvalid[gi]),
        .done   (chan_done[gi])
      );
    end
  endgenerate

  assign s_dvd_tvalid = sel_onehot(sel_reg, chan_tvalid[0]);
  assign s_dvs_tvalid = sel_onehot(sel_reg, chan_tvalid[1]);
  assign s_dvd_tdata  = dvd_reg;
  assign s_dvs_tdata  = dvs_reg;

  // In WAIT the arriving result is forwarded so res_valid costs no extra cycle
  assign res_data  = (state_reg == ST_WAIT) ? dout_data : res_reg;
  assign res_quot  = quot_of(res_data);
  assign res_rem   = rem_of(res_data);
  assign res_valid = (state_reg == ST_DONE) |
                     ((state_reg == ST_WAIT) & dout_sel & ~cancel);
  assign busy      = (state_reg != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      sel_reg         <= 1'b0;
      cancel_pend_reg <= 1'b0;
      dvd_reg         <= '0;
      dvs_reg         <= '0;
      res_reg         <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_req) begin
            dvd_reg         <= req_dividend;
            dvs_reg         <= req_divisor;
            sel_reg         <= req_signed;
            cancel_pend_reg <= 1'b0;
            state_reg       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (chan_done[0] && chan_done[1]) begin
            state_reg <= (cancel_pend_reg || cancel) ? ST_DRAIN : ST_WAIT;
          end else if (cancel) begin
            // Once any beat reached the IP a result will come and must be drained
            if (!chan_done[0] && !chan_done[1]) begin
              state_reg <= ST_IDLE;
            end else begin
              cancel_pend_reg <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cancel) begin
            state_reg <= dout_sel ? ST_IDLE : ST_DRAIN;
          end else if (dout_sel) begin
            res_reg   <= dout_data;
            state_reg <= res_accept ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: begin
          if (cancel || res_accept) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (dout_sel) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural model of the two divider IPs.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_signed, cancel, res_accept;
  logic [31:0] req_dividend, req_divisor;
  logic        res_valid, busy;
  logic [31:0] res_quot, res_rem;
  logic [1:0]  s_dvd_tvalid, s_dvs_tvalid, s_dvd_tready, s_dvs_tready;
  logic [31:0] s_dvd_tdata, s_dvs_tdata;
  logic [1:0]  m_dout_tvalid;
  logic [63:0] m_dout_tdata_s, m_dout_tdata_u;

  div_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_signed     (req_signed),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .cancel         (cancel),
    .res_accept     (res_accept),
    .res_valid      (res_valid),
    .res_quot       (res_quot),
    .res_rem        (res_rem),
    .busy           (busy),
    .s_dvd_tvalid   (s_dvd_tvalid),
    .s_dvs_tvalid   (s_dvs_tvalid),
    .s_dvd_tready   (s_dvd_tready),
    .s_dvs_tready   (s_dvs_tready),
    .s_dvd_tdata    (s_dvd_tdata),
    .s_dvs_tdata    (s_dvs_tdata),
    .m_dout_tvalid  (m_dout_tvalid),
    .m_dout_tdata_s (m_dout_tdata_s),
    .m_dout_tdata_u (m_dout_tdata_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int req_base = 0;
  int lat = 10;
  logic dvd_rdy = 1'b1;
  logic dvs_rdy = 1'b1;
  bit seen_u = 0;
  bit seen_s = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h required 0x%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- divider IP model ----------------
  logic [1:0]  got_dvd = 2'b00;
  logic [1:0]  got_dvs = 2'b00;
  logic [31:0] ip_dvd [2];
  logic [31:0] ip_dvs [2];
  logic [63:0] ip_res [2] = '{64'd0, 64'd0};
  int          ip_cnt [2] = '{0, 0};

  function automatic logic [63:0] div_model(input int sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (sgn != 0) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  assign s_dvd_tready   = {2{dvd_rdy}};
  assign s_dvs_tready   = {2{dvs_rdy}};
  assign m_dout_tvalid  = {ip_cnt[1] == 1, ip_cnt[0] == 1};
  assign m_dout_tdata_s = ip_res[1];
  assign m_dout_tdata_u = ip_res[0];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        got_dvd[i] <= 1'b0;
        got_dvs[i] <= 1'b0;
        ip_cnt[i]  <= 0;
      end else begin
        if (s_dvd_tvalid[i] && s_dvd_tready[i]) begin
          got_dvd[i] <= 1'b1;
          ip_dvd[i]  <= s_dvd_tdata;
        end
        if (s_dvs_tvalid[i] && s_dvs_tready[i]) begin
          got_dvs[i] <= 1'b1;
          ip_dvs[i]  <= s_dvs_tdata;
        end
        if ((got_dvd[i] || (s_dvd_tvalid[i] && s_dvd_tready[i])) &&
            (got_dvs[i] || (s_dvs_tvalid[i] && s_dvs_tready[i]))) begin
          got_dvd[i] <= 1'b0;
          got_dvs[i] <= 1'b0;
          ip_cnt[i]  <= lat + 1;
          ip_res[i]  <= div_model(i,
                          (s_dvd_tvalid[i] && s_dvd_tready[i]) ? s_dvd_tdata : ip_dvd[i],
                          (s_dvs_tvalid[i] && s_dvs_tready[i]) ? s_dvs_tdata : ip_dvs[i]);
        end else if (ip_cnt[i] > 0) begin
          ip_cnt[i] <= ip_cnt[i] - 1;
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin : monitor
    exp_t        e;
    bit          holding;
    logic [31:0] hq, hr;
    holding = 0;
    forever begin
      @(negedge clk);
      if (reset || !res_valid) begin
        holding = 0;
      end else begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got quot 0x%h rem 0x%h, required no result (cycle %0d)",
                     res_quot, res_rem, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("quot", res_quot, e.q);
            chk("rem", res_rem, e.r);
            if (e.lat >= 0) chk("latency", 32'(cyc - req_base), 32'(e.lat));
            $display("[TB] result quot=0x%h rem=0x%h at cycle %0d", res_quot, res_rem, cyc);
          end
          hq = res_quot;
          hr = res_rem;
        end else begin
          chk("hold_quot", res_quot, hq);
          chk("hold_rem", res_rem, hr);
        end
        holding = !(res_accept || cancel);
      end
    end
  end

  // Divisor channel: a pending beat must keep tvalid and data until accepted
  initial begin : axis_mon
    logic [1:0]  pend_v;
    logic [31:0] pend_d;
    pend_v = 2'b00;
    pend_d = '0;
    forever begin
      @(negedge clk);
      if (!reset && pend_v != 2'b00) begin
        chk("axis_dvs_tvalid_held", 32'(s_dvs_tvalid & pend_v), 32'(pend_v));
        chk("axis_dvs_tdata_held", s_dvs_tdata, pend_d);
      end
      pend_v = s_dvs_tvalid & ~s_dvs_tready;
      pend_d = s_dvs_tdata;
    end
  end

  initial begin : tv_mon
    forever begin
      @(negedge clk);
      if (s_dvd_tvalid[0] || s_dvs_tvalid[0]) seen_u = 1;
      if (s_dvd_tvalid[1] || s_dvs_tvalid[1]) seen_s = 1;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int k);
    while (cyc < req_base + k) step();
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit rebase);
    req_signed   = sgn;
    req_dividend = a;
    req_divisor  = b;
    req_valid    = 1'b1;
    if (rebase) req_base = cyc;
  endtask

  task automatic push(input logic [31:0] q, input logic [31:0] r, input int l);
    exp_t e;
    e.q = q;
    e.r = r;
    e.lat = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_res(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (res_valid) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_res: res_valid 0 for %0d cycles, required 1", maxc);
  endtask

  task automatic finish_req();
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_signed = 1'b0;
    req_dividend = '0;
    req_divisor = '0;
    cancel = 1'b0;
    res_accept = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({busy, res_valid, s_dvd_tvalid, s_dvs_tvalid}), 32'd0);
    chk("reset_quot", res_quot, 32'd0);
    chk("reset_rem", res_rem, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Signed -7/2, IP latency 10, immediate accept
    lat = 10;
    res_accept = 1'b1;
    seen_u = 0;
    seen_s = 0;
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    push(32'hFFFF_FFFD, 32'hFFFF_FFFF, 12);
    wait_res(40);
    finish_req();
    @(negedge clk);
    chk("t1_idle_after_accept", 32'(busy), 32'd0);
    chk("t1_unsigned_ip_quiet", 32'(seen_u), 32'd0);
    chk("t1_signed_ip_used", 32'(seen_s), 32'd1);

    // Unsigned 100/7 held in DONE for 5 cycles
    step();
    lat = 3;
    res_accept = 1'b0;
    issue(1'b0, 32'd100, 32'd7, 1);
    push(32'd14, 32'd2, 5);
    wait_res(40);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("t2_done_hold", 32'({busy, res_valid}), 32'd3);
    end
    step();
    res_accept = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_valid_at_accept", 32'(res_valid), 32'd1);
    step();
    @(negedge clk);
    chk("t2_idle_after_accept", 32'(busy), 32'd0);

    // Divisor stalled, cancel after dividend went out: must drain
    step();
    lat = 4;
    dvs_rdy = 1'b0;
    issue(1'b0, 32'h1234_5678, 32'd9, 1);
    goto_cyc(2);
    cancel = 1'b1;
    req_valid = 1'b0;
    req_dividend = 32'hCAFE_F00D;
    req_divisor = 32'hDEAD_BEEF;
    goto_cyc(3);
    cancel = 1'b0;
    @(negedge clk);
    chk("t3_dvs_still_valid", 32'(s_dvs_tvalid), 32'd1);
    goto_cyc(4);
    dvs_rdy = 1'b1;
    @(negedge clk);
    chk("t3_dvs_sent_c4", 32'(s_dvs_tvalid), 32'd1);
    chk("t3_dvs_latched", s_dvs_tdata, 32'd9);
    for (int k = 5; k <= 9; k++) begin
      goto_cyc(k);
      if (k == 6) begin
        issue(1'b0, 32'd20, 32'd6, 0);
        push(32'd3, 32'd2, -1);
      end
      @(negedge clk);
      chk("t3_drain_no_accept", 32'({busy, s_dvd_tvalid, res_valid}), 32'b1000);
    end
    goto_cyc(10);
    @(negedge clk);
    chk("t3_idle_after_dout", 32'(busy), 32'd0);
    goto_cyc(11);
    @(negedge clk);
    chk("t3_new_req_tvalid", 32'(s_dvd_tvalid), 32'd1);
    chk("t3_new_req_data", s_dvd_tdata, 32'd20);
    wait_res(40);
    finish_req();

    // Cancel in WAIT, next request 9/3 held on req_valid
    lat = 6;
    issue(1'b0, 32'd77, 32'd5, 1);
    goto_cyc(3);
    cancel = 1'b1;
    req_dividend = 32'd9;
    req_divisor = 32'd3;
    push(32'd3, 32'd0, -1);
    @(negedge clk);
    chk("t4_cancel_no_valid", 32'(res_valid), 32'd0);
    goto_cyc(4);
    cancel = 1'b0;
    @(negedge clk);
    chk("t4_drain_ignores_req", 32'({busy, s_dvd_tvalid}), 32'b100);
    wait_res(40);
    finish_req();

    // Cancel in the same cycle as dout
    lat = 3;
    issue(1'b0, 32'd40, 32'd4, 1);
    goto_cyc(5);
    cancel = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5_dout_seen", 32'(m_dout_tvalid), 32'd1);
    chk("t5_cancel_masks_valid", 32'(res_valid), 32'd0);
    goto_cyc(6);
    cancel = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_cancel", 32'(busy), 32'd0);

    // Reset in WAIT, then 10/3
    step();
    lat = 10;
    issue(1'b0, 32'd11, 32'd2, 1);
    goto_cyc(3);
    @(negedge clk);
    chk("t6_busy_before_reset", 32'(busy), 32'd1);
    goto_cyc(4);
    reset = 1'b1;
    req_valid = 1'b0;
    goto_cyc(5);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_reset_ctrl", 32'({busy, res_valid, s_dvd_tvalid, s_dvs_tvalid}), 32'd0);
    chk("t6_reset_quot", res_quot, 32'd0);
    chk("t6_reset_rem", res_rem, 32'd0);
    step();
    issue(1'b0, 32'd10, 32'd3, 1);
    push(32'd3, 32'd1, 12);
    wait_res(40);
    finish_req();

    repeat (20) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
